// File: rtl/defog_recover_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : defog_recover_pipe
//  Description : Scene-radiance recovery for the DCP dehazing pipeline.
//                J = (I - A) * TMAX / max(t, T0) + A, rounded half-up and
//                clipped to the channel range. Three register stages. The
//                atmospheric light and the bypass flag are frame-synchronous.
//                Clipped (saturated) pixels are counted per frame.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module defog_recover_pipe #(
    parameter int DW   = 8,
    parameter int CH   = 3,
    parameter int TW   = 8,
    parameter int T0   = 26,
    parameter int FRAC = 12,
    parameter int CW   = 24
) (
    input  logic               pixelclk,
    input  logic               reset_n,
    input  logic [CH*DW-1:0]   i_rgb,
    input  logic [TW-1:0]      i_transmittance,
    input  logic [CH*DW-1:0]   i_atmos,
    input  logic               i_bypass,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_de,
    output logic [CH*DW-1:0]   o_defogging,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [CW-1:0]      o_sat_count
);

    // Reciprocal width, product width
    localparam int c_RW = FRAC + TW;
    localparam int c_PW = DW + FRAC + TW + 2;

    // Transmittance floor as a TW-bit value
    localparam logic [TW-1:0] c_T0 = TW'(T0);
    // 2^FRAC * TMAX, the constant numerator of the reciprocal
    localparam logic [c_RW-1:0] c_NUM = {{TW{1'b1}}, {FRAC{1'b0}}};
    // Unity gain (t = TMAX); used to make bypass an exact identity
    localparam logic [c_RW-1:0] c_ONE = c_RW'(1) << FRAC;
    // Rounding offset 2^(FRAC-1)
    localparam logic signed [c_PW-1:0] c_HALF = c_PW'(1) << (FRAC - 1);
    // Largest representable channel value
    localparam logic signed [c_PW-1:0] c_JMAX = c_PW'((1 << DW) - 1);
    // Sticky ceiling of the saturation counter
    localparam logic [CW-1:0] c_CMAX = '1;

    // Frame-start detection and frame shadows
    logic                    r_vsync_d;
    logic [CH*DW-1:0]        r_a_act;
    logic                    r_byp_act;
    logic                    w_fs;
    logic [CH*DW-1:0]        w_a_eff;
    logic                    w_byp_eff;

    // Stage 1
    logic [TW-1:0]           w_tc;
    logic [c_RW-1:0]         w_recip;
    logic signed [DW:0]      w_d [CH];
    logic [c_RW-1:0]         r_s1_recip;
    logic signed [DW:0]      r_s1_d [CH];
    logic [CH*DW-1:0]        r_s1_a;
    logic                    r_s1_byp;
    logic [2:0]              r_s1_tim;

    // Stage 2
    logic signed [c_PW-1:0]  w_p [CH];
    logic signed [c_PW-1:0]  r_s2_p [CH];
    logic [CH*DW-1:0]        r_s2_a;
    logic                    r_s2_byp;
    logic [2:0]              r_s2_tim;

    // Stage 3
    logic signed [c_PW-1:0]  w_q [CH];
    logic [CH-1:0]           w_clip;
    logic [CH*DW-1:0]        w_j;
    logic                    w_sat;
    logic                    r_s3_sat;

    // Saturation counter
    logic                    r_ovs_d;
    logic [CW-1:0]           r_run;

    // The pixel that coincides with frame start already uses the new values
    assign w_fs      = i_vsync & ~r_vsync_d;
    assign w_a_eff   = w_fs ? i_atmos  : r_a_act;
    assign w_byp_eff = w_fs ? i_bypass : r_byp_act;

    // Capture atmospheric light and bypass only on a rising edge of vsync
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            r_vsync_d <= 1'b0;
            r_a_act   <= '1;
            r_byp_act <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            if (w_fs) begin
                r_a_act   <= i_atmos;
                r_byp_act <= i_bypass;
            end
        end
    end

    // Floor the transmittance and form the reciprocal gain (unity in bypass)
    always_comb begin
        w_tc    = (i_transmittance < c_T0) ? c_T0 : i_transmittance;
        w_recip = w_byp_eff ? c_ONE : (c_NUM / {{FRAC{1'b0}}, w_tc});
    end

    // Per-channel datapath: difference, product, rounding, offset and clip
    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            localparam int c_LO = (CH - 1 - g) * DW;
            logic w_lo;
            logic w_hi;

            assign w_d[g] = $signed({1'b0, i_rgb[c_LO +: DW]})
                          - $signed({1'b0, w_a_eff[c_LO +: DW]});

            assign w_p[g] = c_PW'(r_s1_d[g]) * c_PW'($signed({1'b0, r_s1_recip}));

            assign w_q[g] = ((r_s2_p[g] + c_HALF) >>> FRAC)
                          + $signed({{(c_PW - DW){1'b0}}, r_s2_a[c_LO +: DW]});

            assign w_lo      = w_q[g][c_PW-1];
            assign w_hi      = !w_lo && (w_q[g] > c_JMAX);
            assign w_clip[g] = w_lo | w_hi;
            assign w_j[c_LO +: DW] = w_lo ? '0 : (w_hi ? '1 : w_q[g][DW-1:0]);
        end
    endgenerate

    // Only visible pixels outside bypass may count as saturated
    assign w_sat = (|w_clip) & r_s2_tim[0] & ~r_s2_byp;

    // Stage 1: register reciprocal, differences, A, bypass and timing
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            r_s1_recip <= '0;
            for (int c = 0; c < CH; c++) r_s1_d[c] <= '0;
            r_s1_a     <= '0;
            r_s1_byp   <= 1'b0;
            r_s1_tim   <= '0;
        end else begin
            r_s1_recip <= w_recip;
            for (int c = 0; c < CH; c++) r_s1_d[c] <= w_d[c];
            r_s1_a     <= w_a_eff;
            r_s1_byp   <= w_byp_eff;
            r_s1_tim   <= {i_hsync, i_vsync, i_de};
        end
    end

    // Stage 2: register the scaled differences
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) r_s2_p[c] <= '0;
            r_s2_a   <= '0;
            r_s2_byp <= 1'b0;
            r_s2_tim <= '0;
        end else begin
            for (int c = 0; c < CH; c++) r_s2_p[c] <= w_p[c];
            r_s2_a   <= r_s1_a;
            r_s2_byp <= r_s1_byp;
            r_s2_tim <= r_s1_tim;
        end
    end

    // Stage 3: register the recovered pixel, timing and saturation flag
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            o_defogging <= '0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_de        <= 1'b0;
            r_s3_sat    <= 1'b0;
        end else begin
            o_defogging <= w_j;
            o_hsync     <= r_s2_tim[2];
            o_vsync     <= r_s2_tim[1];
            o_de        <= r_s2_tim[0];
            r_s3_sat    <= w_sat;
        end
    end

    // Count saturated output pixels; publish and restart on output vsync rise
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            r_ovs_d     <= 1'b0;
            r_run       <= '0;
            o_sat_count <= '0;
        end else begin
            r_ovs_d <= o_vsync;
            if (o_vsync && !r_ovs_d) begin
                o_sat_count <= r_run;
                r_run       <= CW'(r_s3_sat);
            end else if (r_s3_sat && (r_run != c_CMAX)) begin
                r_run <= r_run + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_defog_recover_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_defog_recover_pipe
//  Description : Self-checking bench for defog_recover_pipe. A behavioural
//                model predicts every output cycle; directed scenarios add
//                hand-computed literal expectations, then a random stream
//                with occasional resets follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_defog_recover_pipe;

    localparam int CH    = 3;
    localparam int T0    = 26;
    localparam int MAX24 = 16777215;
    localparam int MAX4  = 15;

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic [23:0] i_rgb;
    logic [7:0]  i_transmittance;
    logic [23:0] i_atmos;
    logic        i_bypass, i_hsync, i_vsync, i_de;

    logic [23:0] o_defogging, o_defogging4;
    logic        o_hsync, o_vsync, o_de;
    logic        o_hsync4, o_vsync4, o_de4;
    logic [23:0] o_sat_count;
    logic [3:0]  o_sat_count4;

    always #5 pixelclk = ~pixelclk;

    defog_recover_pipe #(.DW(8), .CH(3), .TW(8), .T0(26), .FRAC(12), .CW(24)) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_rgb(i_rgb),
        .i_transmittance(i_transmittance), .i_atmos(i_atmos), .i_bypass(i_bypass),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .o_defogging(o_defogging), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_de(o_de), .o_sat_count(o_sat_count)
    );

    defog_recover_pipe #(.DW(8), .CH(3), .TW(8), .T0(26), .FRAC(12), .CW(4)) dut4 (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_rgb(i_rgb),
        .i_transmittance(i_transmittance), .i_atmos(i_atmos), .i_bypass(i_bypass),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .o_defogging(o_defogging4), .o_hsync(o_hsync4), .o_vsync(o_vsync4),
        .o_de(o_de4), .o_sat_count(o_sat_count4)
    );

    typedef struct { logic [23:0] rgb; bit hs; bit vs; bit de; bit sat; } ent_t;

    ent_t        e_hist [3];
    bit          rst_hist [3];
    ent_t        exp_o;
    ent_t        o_prev2;
    bit          exp_zero;
    logic [23:0] m_a;
    bit          m_byp, m_pvs;
    int          m_run, m_cnt, m_run4, m_cnt4;
    int          checks = 0;
    int          failures = 0;
    logic [23:0] cur_atm;
    bit          cur_byp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Recovery formula for one channel, straight from the arithmetic rules
    function automatic void calc(input logic [7:0] iv, input logic [7:0] av,
                                 input logic [7:0] tv, output logic [7:0] j, output bit clip);
        longint tc, recip, p, q;
        tc    = (int'(tv) < T0) ? longint'(T0) : longint'(tv);
        recip = (longint'(4096) * 255) / tc;
        p     = (longint'(iv) - longint'(av)) * recip;
        q     = ((p + 2048) >>> 12) + longint'(av);
        clip  = (q < 0) || (q > 255);
        if (q < 0)        j = 8'd0;
        else if (q > 255) j = 8'd255;
        else              j = q[7:0];
    endfunction

    function automatic logic [23:0] rep(input logic [7:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [23:0] vec(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b, b ^ 8'h5a};
    endfunction

    // Advance the model by one clock edge using the inputs just sampled
    task automatic model_edge();
        ent_t       e;
        bit         rs, clip, anyclip;
        logic [7:0] j;
        e  = '{default: 0};
        rs = !reset_n;
        if (rs) begin
            m_a = '1; m_byp = 0; m_pvs = 0;
        end else begin
            if (i_vsync && !m_pvs) begin
                m_a   = i_atmos;
                m_byp = i_bypass;
            end
            m_pvs   = i_vsync;
            anyclip = 0;
            for (int c = 0; c < CH; c++) begin
                calc(i_rgb[c*8 +: 8], m_a[c*8 +: 8], i_transmittance, j, clip);
                e.rgb[c*8 +: 8] = m_byp ? i_rgb[c*8 +: 8] : j;
                anyclip = anyclip | clip;
            end
            e.hs  = i_hsync;
            e.vs  = i_vsync;
            e.de  = i_de;
            e.sat = !m_byp && i_de && anyclip;
        end
        // frame accounting over the output stream of the previous cycle
        if (rs) begin
            m_run = 0; m_cnt = 0; m_run4 = 0; m_cnt4 = 0;
        end else if (exp_o.vs && !o_prev2.vs) begin
            m_cnt  = m_run;
            m_cnt4 = m_run4;
            m_run  = int'(exp_o.sat);
            m_run4 = int'(exp_o.sat);
        end else if (exp_o.sat) begin
            if (m_run < MAX24) m_run++;
            if (m_run4 < MAX4) m_run4++;
        end
        e_hist[2]   = e_hist[1];
        e_hist[1]   = e_hist[0];
        e_hist[0]   = e;
        rst_hist[2] = rst_hist[1];
        rst_hist[1] = rst_hist[0];
        rst_hist[0] = rs;
        exp_zero    = rst_hist[0] || rst_hist[1] || rst_hist[2];
        o_prev2     = exp_o;
        exp_o       = exp_zero ? '{default: 0} : e_hist[2];
    endtask

    task automatic compare();
        chk("hsync", o_hsync, exp_o.hs);
        chk("vsync", o_vsync, exp_o.vs);
        chk("de", o_de, exp_o.de);
        chk("hsync_cw4", o_hsync4, exp_o.hs);
        chk("vsync_cw4", o_vsync4, exp_o.vs);
        chk("de_cw4", o_de4, exp_o.de);
        if (exp_o.de || exp_zero) begin
            chk("pixel", o_defogging, exp_o.rgb);
            chk("pixel_cw4", o_defogging4, exp_o.rgb);
        end
        chk("sat_count", o_sat_count, m_cnt);
        chk("sat_count_cw4", o_sat_count4, m_cnt4);
    endtask

    task automatic step(input logic [23:0] rgb, input logic [7:0] t, input logic [23:0] atm,
                        input bit byp, input bit hs, input bit vs, input bit de, input bit rn);
        i_rgb = rgb; i_transmittance = t; i_atmos = atm; i_bypass = byp;
        i_hsync = hs; i_vsync = vs; i_de = de; reset_n = rn;
        @(posedge pixelclk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic px(input logic [23:0] rgb, input logic [7:0] t, input bit vs, input bit de);
        step(rgb, t, cur_atm, cur_byp, 1'b0, vs, de, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            e_hist[k]   = '{default: 0};
            rst_hist[k] = 1;
        end
        exp_o = '{default: 0}; o_prev2 = '{default: 0};
        m_a = '1; m_byp = 0; m_pvs = 0;
        m_run = 0; m_cnt = 0; m_run4 = 0; m_cnt4 = 0; exp_zero = 1;
        cur_atm = rep(8'd220); cur_byp = 0;

        // reset
        repeat (3) step(24'd0, 8'd0, cur_atm, 0, 0, 0, 0, 0);
        chk("reset_pixel", o_defogging, 0);
        chk("reset_timing", {o_hsync, o_vsync, o_de}, 0);
        chk("reset_sat_count", o_sat_count, 0);

        // frame A: nominal pixel, then five clipped pixels
        px(rep(8'd200), 8'd128, 1, 1);
        px(rep(8'd200), 8'd255, 0, 0);
        px(rep(8'd200), 8'd255, 0, 0);
        chk("t128_pixel", o_defogging, rep(8'd180));
        chk("t128_de", o_de, 1);
        px(rep(8'd0), 8'd0, 0, 1);
        px(rep(8'd0), 8'd0, 0, 1);
        px(rep(8'd0), 8'd0, 0, 1);
        chk("clip_low", o_defogging, rep(8'd0));
        px(rep(8'd250), 8'd64, 0, 1);
        px(rep(8'd250), 8'd64, 0, 1);
        cur_atm = rep(8'd100);
        px(rep(8'd200), 8'd128, 0, 1);
        px(rep(8'd0), 8'd255, 0, 0);
        px(rep(8'd0), 8'd255, 0, 0);
        chk("atmos_held", o_defogging, rep(8'd180));

        // frame B: new atmospheric light, clip high, count of frame A
        px(rep(8'd250), 8'd64, 1, 1);
        px(rep(8'd100), 8'd128, 0, 1);
        px(rep(8'd100), 8'd128, 0, 1);
        chk("clip_high", o_defogging, rep(8'd255));
        px(rep(8'd100), 8'd128, 0, 1);
        chk("frame_sat_count", o_sat_count, 5);
        chk("frame_sat_count_cw4", o_sat_count4, 5);
        cur_byp = 1;
        px(rep(8'd250), 8'd64, 0, 1);

        // frame C: bypass
        px(rep(8'd250), 8'd64, 1, 1);
        px(rep(8'd0), 8'd0, 0, 1);
        px(rep(8'd0), 8'd0, 0, 1);
        chk("bypass_pixel", o_defogging, rep(8'd250));
        px(rep(8'd0), 8'd0, 0, 1);
        cur_byp = 0;

        // frame D: count of the bypass frame
        px(rep(8'd100), 8'd255, 1, 1);
        repeat (3) px(rep(8'd100), 8'd255, 0, 1);
        chk("bypass_sat_count", o_sat_count, 0);

        // frame E: t = TMAX identity sweep
        cur_atm = rep(8'd137);
        for (int i = 0; i < 258; i++) begin
            px((i < 256) ? vec(i) : 24'd0, 8'd255, i == 0, i < 256);
            if (i >= 2) chk("tmax_identity", o_defogging, vec(i - 2));
        end

        // frame F: 20 saturated pixels; frame G starts with a saturated pixel
        cur_atm = rep(8'd220);
        for (int i = 0; i < 20; i++) px(rep(8'd0), 8'd0, i == 0, 1);
        px(rep(8'd0), 8'd0, 1, 1);
        repeat (3) px(rep(8'd0), 8'd255, 0, 1);
        chk("sat_count_20", o_sat_count, 20);
        chk("sat_count_sticky_cw4", o_sat_count4, 15);
        px(rep(8'd0), 8'd255, 1, 1);
        repeat (3) px(rep(8'd0), 8'd255, 0, 1);
        chk("sat_coincident", o_sat_count, 1);
        chk("sat_coincident_cw4", o_sat_count4, 1);

        // mid-line reset and recovery
        px(rep(8'd50), 8'd128, 0, 1);
        px(rep(8'd50), 8'd128, 0, 1);
        step(rep(8'd50), 8'd128, cur_atm, 0, 1, 0, 1, 0);
        chk("mid_reset_out", {o_defogging, o_hsync, o_vsync, o_de, o_sat_count}, 0);
        step(rep(8'd77), 8'd255, cur_atm, 0, 1, 0, 1, 1);
        px(rep(8'd10), 8'd255, 0, 0);
        px(rep(8'd10), 8'd255, 0, 0);
        chk("recover_pixel", o_defogging, rep(8'd77));
        chk("recover_de", o_de, 1);

        // random stream with sporadic resets
        for (int n = 0; n < 3000; n++) begin
            step(24'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255)),
                 24'($urandom),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 149) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
